// File: rtl/ram_dp_clr.sv
// Dual-port main-memory RAM: a read/write CPU port and a read-only debug port.
// A clear engine fills every word with FILL after reset or on request, stalling the CPU via busy.
module ram_dp_clr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADRS_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL = '0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADRS_WIDTH-1:0] adrs,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] q,
  input  logic [ADRS_WIDTH-1:0] dbg_adrs,
  output logic [DATA_WIDTH-1:0] dbg_q,
  input  logic                  clr,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 1 << ADRS_WIDTH;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_CLEAR = 2'b01;

  logic [1:0]            state;
  logic [ADRS_WIDTH-1:0] adrs_reg;
  logic [ADRS_WIDTH-1:0] dbg_adrs_reg;
  logic [ADRS_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADRS_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  // Single array write port shared by the CPU and the clear engine; a restart rewrites word 0.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = adrs;
    mem_wd = data;
    case (state)
      ST_IDLE: begin
        if (!clr && wr_en) mem_we = 1'b1;
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr ? '0 : clr_ptr;
        mem_wd = FILL;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // The array is never affected by reset, but no write lands while reset is held.
  always_ff @(negedge clock) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      adrs_reg     <= '0;
      dbg_adrs_reg <= '0;
      clr_ptr      <= '0;
      wr_drop      <= 1'b0;
      state        <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    end else begin
      adrs_reg     <= adrs;
      dbg_adrs_reg <= dbg_adrs;
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            wr_drop <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr) begin
            clr_ptr <= '0;
            wr_drop <= 1'b0;
          end else begin
            if (wr_en) wr_drop <= 1'b1;
            if (&clr_ptr) state <= ST_IDLE;
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state == ST_CLEAR);
  assign q     = busy ? FILL : mem[adrs_reg];
  assign dbg_q = mem[dbg_adrs_reg];

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: three instances cover clear-on-reset with FILL 00 and FF,
// and a reset that preserves memory contents.
module tb_ram_dp_clr;

  logic       clock = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [7:0] adrs = '0, data = '0, dbg_adrs = '0;
  logic       wr_en = 1'b0, clr = 1'b0;
  logic [7:0] q_a, dbg_q_a, q_b, dbg_q_b, q_c, dbg_q_c;
  logic       busy_a, busy_b, busy_c, wr_drop_a, wr_drop_b, wr_drop_c;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n;
  int         bad;

  always #5 clock = ~clock;

  ram_dp_clr #(.DATA_WIDTH(8), .ADRS_WIDTH(8), .FILL(8'h00), .CLEAR_ON_RESET(1)) u_a (
    .clock(clock), .reset(rst_a), .adrs(adrs), .data(data), .wr_en(wr_en), .q(q_a),
    .dbg_adrs(dbg_adrs), .dbg_q(dbg_q_a), .clr(clr), .busy(busy_a), .wr_drop(wr_drop_a));

  ram_dp_clr #(.DATA_WIDTH(8), .ADRS_WIDTH(8), .FILL(8'h00), .CLEAR_ON_RESET(0)) u_b (
    .clock(clock), .reset(rst_b), .adrs(adrs), .data(data), .wr_en(wr_en), .q(q_b),
    .dbg_adrs(dbg_adrs), .dbg_q(dbg_q_b), .clr(clr), .busy(busy_b), .wr_drop(wr_drop_b));

  ram_dp_clr #(.DATA_WIDTH(8), .ADRS_WIDTH(8), .FILL(8'hFF), .CLEAR_ON_RESET(1)) u_c (
    .clock(clock), .reset(rst_c), .adrs(adrs), .data(data), .wr_en(wr_en), .q(q_c),
    .dbg_adrs(dbg_adrs), .dbg_q(dbg_q_c), .clr(clr), .busy(busy_c), .wr_drop(wr_drop_c));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic [7:0] da,
                               input logic we, input logic c);
    adrs = a;
    data = d;
    dbg_adrs = da;
    wr_en = we;
    clr = c;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each negedge.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0: busy_of = busy_a;
      1: busy_of = busy_b;
      default: busy_of = busy_c;
    endcase
  endfunction

  // Counts negedges until busy falls, bounded so a stuck engine still reaches the summary.
  task automatic wait_idle(input int sel, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy_of(sel) && cnt < 1000);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick(); tick();
    checkOutput("a_reset_busy", busy_a, 1);
    checkOutput("a_reset_q_fill", q_a, 8'h00);
    checkOutput("a_reset_wr_drop", wr_drop_a, 0);
    checkOutput("b_reset_busy", busy_b, 0);
    checkOutput("c_reset_busy", busy_c, 1);
    checkOutput("c_reset_q_fill", q_c, 8'hFF);

    // Test 1: preload AA, pulse reset, clear takes 256 negedges
    rst_a = 1'b0;
    wait_idle(0, n);
    checkOutput("a_init_clear_len", n, 256);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(i[7:0], 8'hAA, 8'h00, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("a_preload_q", q_a, 8'hAA);
    checkOutput("a_preload_dbg", dbg_q_a, 8'hAA);
    rst_a = 1'b1;
    #1;
    checkOutput("a_reset_busy_async", busy_a, 1);
    checkOutput("a_reset_q_async", q_a, 8'h00);
    #2 rst_a = 1'b0;
    wait_idle(0, n);
    checkOutput("a_clear_len", n, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(i[7:0], 8'h00, 8'(255 - i), 1'b0, 1'b0);
      tick();
      if (q_a !== 8'h00 || dbg_q_a !== 8'h00) bad++;
    end
    checkOutput("a_clear_words_bad", bad, 0);

    // Test 2: writes and reads in IDLE, including read-during-write
    applyStimulus(8'h00, 8'h81, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("rdw_q_00", q_a, 8'h81);
    checkOutput("rdw_dbg_00", dbg_q_a, 8'h81);
    applyStimulus(8'h01, 8'h07, 8'h01, 1'b1, 1'b0);
    #1;
    checkOutput("latency_q_old", q_a, 8'h81);
    tick();
    checkOutput("rdw_q_01", q_a, 8'h07);
    checkOutput("rdw_dbg_01", dbg_q_a, 8'h07);
    applyStimulus(8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
    tick();
    checkOutput("read_q_00", q_a, 8'h81);
    checkOutput("read_dbg_01", dbg_q_a, 8'h07);

    // Test 3: write dropped at clear step 5 sets sticky wr_drop
    applyStimulus(8'h10, 8'h99, 8'h10, 1'b1, 1'b0);
    tick();
    checkOutput("pre_write_10", dbg_q_a, 8'h99);
    applyStimulus(8'h10, 8'h00, 8'h10, 1'b0, 1'b1);
    tick();
    checkOutput("clr_start_busy", busy_a, 1);
    checkOutput("clr_start_wr_drop", wr_drop_a, 0);
    applyStimulus(8'h10, 8'h00, 8'h10, 1'b0, 1'b0);
    repeat (5) tick();
    applyStimulus(8'h10, 8'h55, 8'h10, 1'b1, 1'b0);
    tick();
    checkOutput("drop_mem_unchanged", dbg_q_a, 8'h99);
    checkOutput("drop_wr_drop_set", wr_drop_a, 1);
    checkOutput("busy_q_forced", q_a, 8'h00);
    applyStimulus(8'h10, 8'h00, 8'h10, 1'b0, 1'b0);
    wait_idle(0, n);
    checkOutput("clr_len_after_step5", n, 250);
    checkOutput("wr_drop_sticky", wr_drop_a, 1);
    checkOutput("cleared_10", dbg_q_a, 8'h00);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("wr_drop_cleared", wr_drop_a, 0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle(0, n);
    checkOutput("clr_len_plain", n, 256);

    // Test 4: restart at step 100 gives 101 + 256 busy negedges
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (100) tick();
    checkOutput("restart_busy_before", busy_a, 1);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle(0, n);
    checkOutput("restart_total_len", 101 + n, 357);

    // Test 5: reset without clear keeps memory
    rst_a = 1'b1;
    rst_b = 1'b0;
    applyStimulus(8'h00, 8'h5A, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(8'hFF, 8'h3C, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("b_write_ff_q", q_b, 8'h3C);
    checkOutput("b_write_ff_dbg", dbg_q_b, 8'h3C);
    applyStimulus(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    #1 rst_b = 1'b1;
    #1;
    checkOutput("b_reset_busy_async", busy_b, 0);
    checkOutput("b_reset_q_async", q_b, 8'h5A);
    checkOutput("b_reset_dbg_async", dbg_q_b, 8'h5A);
    checkOutput("b_reset_wr_drop", wr_drop_b, 0);
    tick();
    rst_b = 1'b0;
    tick();
    checkOutput("b_keep_ff_dbg", dbg_q_b, 8'h3C);
    checkOutput("b_keep_ff_q", q_b, 8'h3C);

    // Test 6: reset at step 50 with FILL FF aborts and restarts the clear
    rst_b = 1'b1;
    rst_c = 1'b0;
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle(2, n);
    checkOutput("c_init_clear_len", n, 256);
    applyStimulus(8'h00, 8'h12, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h80, 8'h34, 8'h80, 1'b1, 1'b0);
    tick();
    checkOutput("c_write_80", dbg_q_c, 8'h34);
    applyStimulus(8'h00, 8'h00, 8'h80, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 8'h00, 8'h80, 1'b0, 1'b0);
    repeat (50) tick();
    checkOutput("c_80_before_reset", dbg_q_c, 8'h34);
    #1 rst_c = 1'b1;
    #1;
    checkOutput("c_reset_busy_async", busy_c, 1);
    checkOutput("c_reset_q_async", q_c, 8'hFF);
    checkOutput("c_reset_filled_word0", dbg_q_c, 8'hFF);
    #2 rst_c = 1'b0;
    tick();
    checkOutput("c_remainder_kept", dbg_q_c, 8'h34);
    wait_idle(2, n);
    checkOutput("c_restart_len", n + 1, 256);
    checkOutput("c_80_filled", dbg_q_c, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
